// File: rtl/snake_field_buffer_if.sv
// Move-command and apple-load bus between the game control FSM and snake_field_buffer.
interface snake_field_buffer_if #(
  parameter int POS_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [POS_W-1:0] cmd_head;
  logic [POS_W-1:0] cmd_tail;
  logic             cmd_grow;
  logic             apple_load;
  logic [POS_W-1:0] apple_pos;

  modport master (
    output cmd_valid, cmd_head, cmd_tail, cmd_grow, apple_load, apple_pos,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_head, cmd_tail, cmd_grow, apple_load, apple_pos,
    output cmd_ready
  );
endinterface

// File: rtl/snake_field_buffer.sv
// Snake body occupancy map + apple for a FIELD_W x FIELD_H field, painted into a bordered LED frame.
// Optional macro APPLE_BLINK_EN makes the apple LED blink with half-period BLINK_DIV clocks.
module snake_field_buffer #(
  parameter int FIELD_W   = 4,
  parameter int FIELD_H   = 4,
  parameter int POS_W     = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic                                 clock,
  input  logic                                 restart,
  snake_field_buffer_if.slave                  bus,
  output logic [(FIELD_W+2)*(FIELD_H+2)-1:0]   leds,
  output logic [POS_W:0]                       body_len,
  output logic                                 ate_apple,
  output logic                                 collision
);

  localparam int N = FIELD_W * FIELD_H;
  localparam int C = FIELD_W + 2;
  localparam int L = C * (FIELD_H + 2);
  localparam logic [POS_W:0] N_L = (POS_W+1)'(N);

  if (FIELD_W < 2 || FIELD_H < 2 || (1 << POS_W) < N || BLINK_DIV < 1) begin : g_param_err
    $error("snake_field_buffer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    UPDATE = 2'd2,
    DEAD   = 2'd3
  } state_t;

  function automatic logic [L-1:0] border_mask();
    logic [L-1:0] m;
    m = '0;
    for (int r = 0; r < FIELD_H + 2; r++) begin
      for (int c = 0; c < C; c++) begin
        if (r == 0 || r == FIELD_H + 1 || c == 0 || c == C - 1) m[r*C+c] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [L-1:0] BORDER = border_mask();

  function automatic logic [L-1:0] paint(input logic [N-1:0] body, input logic show,
                                         input logic [POS_W-1:0] apos);
    logic [L-1:0] f;
    f = BORDER;
    for (int p = 0; p < N; p++) begin
      if (body[p] || (show && apos == POS_W'(p))) f[(p/FIELD_W+1)*C + p%FIELD_W + 1] = 1'b1;
    end
    return f;
  endfunction

  // Safe lookup: indices beyond the field read as empty.
  function automatic logic bit_at(input logic [N-1:0] v, input logic [POS_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (idx == POS_W'(p)) b = v[p];
    end
    return b;
  endfunction

  state_t           state_r, state_nxt;
  logic [POS_W-1:0] head_r, tail_r, apple_pos_r, apple_pos_nxt;
  logic             grow_r, wall_r, self_r, eat_r, grow_eff_r;
  logic [N-1:0]     body_r, body_nxt;
  logic [POS_W:0]   len_r, len_nxt;
  logic             apple_on_r, apple_on_nxt, ate_r, ate_nxt, coll_r, coll_nxt;
  logic [L-1:0]     leds_r;
  logic             wall_s, eat_s, grow_eff_s, self_s, load_ok_s, show_s;

  assign wall_s     = {1'b0, head_r} >= N_L;
  assign eat_s      = apple_on_r && (head_r == apple_pos_r);
  assign grow_eff_s = grow_r | eat_s;
  assign self_s     = bit_at(body_r, head_r) && !((head_r == tail_r) && !grow_eff_s);
  assign load_ok_s  = bus.apple_load && (state_r != DEAD) && ({1'b0, bus.apple_pos} < N_L);

  assign bus.cmd_ready = (state_r == IDLE);
  assign leds          = leds_r;
  assign body_len      = len_r;
  assign ate_apple     = ate_r;
  assign collision     = coll_r;

  always_ff @(posedge clock) begin
    if (restart) state_r <= IDLE;
    else         state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    state_nxt = bus.cmd_valid ? CHECK : IDLE;
      CHECK:   state_nxt = UPDATE;
      UPDATE:  state_nxt = (wall_r || self_r) ? DEAD : IDLE;
      DEAD:    state_nxt = DEAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Body/apple next state; an apple load in the eating cycle overrides the clear.
  always_comb begin
    body_nxt = body_r;
    len_nxt  = len_r;
    ate_nxt  = 1'b0;
    coll_nxt = coll_r;
    apple_on_nxt = apple_on_r;
    if (state_r == UPDATE && (wall_r || self_r)) begin
      coll_nxt = 1'b1;
    end else if (state_r == UPDATE) begin
      for (int p = 0; p < N; p++) begin
        if (head_r == POS_W'(p))                      body_nxt[p] = 1'b1;
        else if (!grow_eff_r && tail_r == POS_W'(p))  body_nxt[p] = 1'b0;
        else                                          body_nxt[p] = body_r[p];
      end
      len_nxt      = (grow_eff_r && len_r < N_L) ? len_r + {{POS_W{1'b0}}, 1'b1} : len_r;
      apple_on_nxt = eat_r ? 1'b0 : apple_on_r;
      ate_nxt      = eat_r;
    end else begin
      coll_nxt = coll_r;
    end
    apple_on_nxt  = load_ok_s ? 1'b1 : apple_on_nxt;
    apple_pos_nxt = load_ok_s ? bus.apple_pos : apple_pos_r;
  end

`ifdef APPLE_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt_r;
  logic          phase_r, phase_nxt, wrap_s;

  assign wrap_s    = (blink_cnt_r == BW'(BLINK_DIV - 1));
  assign phase_nxt = wrap_s ? ~phase_r : phase_r;
  assign show_s    = apple_on_nxt && phase_nxt;

  always_ff @(posedge clock) begin
    if (restart) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b1;
    end else begin
      blink_cnt_r <= wrap_s ? '0 : blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
      phase_r     <= phase_nxt;
    end
  end
`else
  assign show_s = apple_on_nxt;
`endif

  // Latch command, register CHECK results, commit body and repaint the frame.
  always_ff @(posedge clock) begin
    if (restart) begin
      head_r      <= '0;
      tail_r      <= '0;
      grow_r      <= 1'b0;
      wall_r      <= 1'b0;
      self_r      <= 1'b0;
      eat_r       <= 1'b0;
      grow_eff_r  <= 1'b0;
      body_r      <= '0;
      len_r       <= '0;
      apple_on_r  <= 1'b0;
      apple_pos_r <= '0;
      ate_r       <= 1'b0;
      coll_r      <= 1'b0;
      leds_r      <= BORDER;
    end else begin
      if (state_r == IDLE && bus.cmd_valid) begin
        head_r <= bus.cmd_head;
        tail_r <= bus.cmd_tail;
        grow_r <= bus.cmd_grow;
      end else begin
        head_r <= head_r;
        tail_r <= tail_r;
        grow_r <= grow_r;
      end
      if (state_r == CHECK) begin
        wall_r     <= wall_s;
        self_r     <= self_s;
        eat_r      <= eat_s;
        grow_eff_r <= grow_eff_s;
      end else begin
        wall_r     <= wall_r;
        self_r     <= self_r;
        eat_r      <= eat_r;
        grow_eff_r <= grow_eff_r;
      end
      body_r      <= body_nxt;
      len_r       <= len_nxt;
      apple_on_r  <= apple_on_nxt;
      apple_pos_r <= apple_pos_nxt;
      ate_r       <= ate_nxt;
      coll_r      <= coll_nxt;
      leds_r      <= (state_r == DEAD) ? leds_r : paint(body_nxt, show_s, apple_pos_nxt);
    end
  end

endmodule

// File: tb/tb_snake_field_buffer.sv
// Scoreboard bench for snake_field_buffer: default 4x4 instance and a 5x3 instance.
module tb_snake_field_buffer;

  logic clock = 1'b0;
  logic restart = 1'b1;
  always #5 clock = ~clock;

  snake_field_buffer_if #(.POS_W(4)) bus_a ();
  snake_field_buffer_if #(.POS_W(4)) bus_b ();

  logic [35:0] leds_a;
  logic [34:0] leds_b;
  logic [4:0]  len_a, len_b;
  logic        ate_a, ate_b, coll_a, coll_b;

  snake_field_buffer #(.FIELD_W(4), .FIELD_H(4), .POS_W(4), .BLINK_DIV(8)) dut_a (
    .clock(clock), .restart(restart), .bus(bus_a.slave),
    .leds(leds_a), .body_len(len_a), .ate_apple(ate_a), .collision(coll_a)
  );

  snake_field_buffer #(.FIELD_W(5), .FIELD_H(3), .POS_W(4), .BLINK_DIV(8)) dut_b (
    .clock(clock), .restart(restart), .bus(bus_b.slave),
    .leds(leds_b), .body_len(len_b), .ate_apple(ate_b), .collision(coll_b)
  );

  localparam logic [35:0] BORDER_A = 36'hFE186187F;

  typedef struct {
    logic [35:0] leds;
    logic [4:0]  len;
    logic        ate;
    logic        coll;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] border_b();
    logic [35:0] m;
    m = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 7; c++)
        if (r == 0 || r == 4 || c == 0 || c == 6) m[r*7+c] = 1'b1;
    return m;
  endfunction

  function automatic int map_a(input int p);
    return (p / 4 + 1) * 6 + p % 4 + 1;
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus_a.cmd_ready : bus_b.cmd_ready;
  endfunction

  function automatic logic [63:0] leds_of(input int sel);
    return (sel == 0) ? 64'(leds_a) : 64'(leds_b);
  endfunction

  task automatic drive_cmd(input int sel, input logic v, input logic [3:0] h, input logic [3:0] t,
                           input logic g);
    if (sel == 0) begin
      bus_a.cmd_valid = v; bus_a.cmd_head = h; bus_a.cmd_tail = t; bus_a.cmd_grow = g;
    end else begin
      bus_b.cmd_valid = v; bus_b.cmd_head = h; bus_b.cmd_tail = t; bus_b.cmd_grow = g;
    end
  endtask

  task automatic drive_apple(input int sel, input logic ld, input logic [3:0] pos);
    if (sel == 0) begin
      bus_a.apple_load = ld; bus_a.apple_pos = pos;
    end else begin
      bus_b.apple_load = ld; bus_b.apple_pos = pos;
    end
  endtask

  // Issue one move; expected T+3 response goes to the scoreboard queue.
  task automatic send(input int sel, input logic [3:0] h, input logic [3:0] t, input logic g,
                      input logic [35:0] el, input logic [4:0] ln, input logic at,
                      input logic cl, input logic ld, input logic [3:0] lp);
    int n;
    exp_t x;
    n = 0;
    @(posedge clock); #1;
    while (rdy(sel) !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL ready_timeout: sel=%0d cmd_ready stayed %b, expected 1", sel, rdy(sel));
    end else begin
      x = '{el, ln, at, cl};
      if (sel == 0) q_a.push_back(x);
      else          q_b.push_back(x);
      drive_cmd(sel, 1'b1, h, t, g);
      @(posedge clock); #1;
      drive_cmd(sel, 1'b0, h, t, g);
      @(negedge clock);
      check("ready_low_t1", 64'(rdy(sel)), 64'd0);
      @(posedge clock); #1;
      drive_apple(sel, ld, lp);
      @(negedge clock);
      check("ready_low_t2", 64'(rdy(sel)), 64'd0);
      @(posedge clock); #1;
      drive_apple(sel, 1'b0, lp);
      @(negedge clock);
      @(negedge clock);
      check("ate_one_shot", 64'((sel == 0) ? ate_a : ate_b), 64'd0);
    end
  endtask

  task automatic load_apple(input int sel, input logic [3:0] pos, input logic [35:0] el,
                            input string name);
    @(posedge clock); #1;
    drive_apple(sel, 1'b1, pos);
    @(posedge clock); #1;
    drive_apple(sel, 1'b0, pos);
    @(negedge clock);
    check(name, leds_of(sel), 64'(el));
  endtask

  task automatic do_restart();
    @(posedge clock); #1;
    restart = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0;
    @(negedge clock);
  endtask

  // Monitors: a response is the rising edge of cmd_ready or of collision outside restart.
  logic rdy_prev_a = 1'b0, coll_prev_a = 1'b0, rst_prev_a = 1'b1;
  exp_t ea;
  always @(negedge clock) begin
    if (!restart && !rst_prev_a &&
        ((bus_a.cmd_ready && !rdy_prev_a) || (coll_a && !coll_prev_a))) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_a_unexpected: got response leds=%0h, expected none", leds_a);
      end else begin
        ea = q_a.pop_front();
        check("mon_a_leds", 64'(leds_a), 64'(ea.leds));
        check("mon_a_len",  64'(len_a),  64'(ea.len));
        check("mon_a_ate",  64'(ate_a),  64'(ea.ate));
        check("mon_a_coll", 64'(coll_a), 64'(ea.coll));
      end
    end
    rdy_prev_a  = bus_a.cmd_ready;
    coll_prev_a = coll_a;
    rst_prev_a  = restart;
  end

  logic rdy_prev_b = 1'b0, coll_prev_b = 1'b0, rst_prev_b = 1'b1;
  exp_t eb;
  always @(negedge clock) begin
    if (!restart && !rst_prev_b &&
        ((bus_b.cmd_ready && !rdy_prev_b) || (coll_b && !coll_prev_b))) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_b_unexpected: got response leds=%0h, expected none", leds_b);
      end else begin
        eb = q_b.pop_front();
        check("mon_b_leds", 64'(leds_b), 64'(eb.leds));
        check("mon_b_len",  64'(len_b),  64'(eb.len));
        check("mon_b_ate",  64'(ate_b),  64'(eb.ate));
        check("mon_b_coll", 64'(coll_b), 64'(eb.coll));
      end
    end
    rdy_prev_b  = bus_b.cmd_ready;
    coll_prev_b = coll_b;
    rst_prev_b  = restart;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] ef, bb;
    drive_cmd(0, 1'b0, 4'd0, 4'd0, 1'b0);
    drive_cmd(1, 1'b0, 4'd0, 4'd0, 1'b0);
    drive_apple(0, 1'b0, 4'd0);
    drive_apple(1, 1'b0, 4'd0);
    restart = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0;
    @(negedge clock);
    check("reset_leds",  64'(leds_a), 64'(BORDER_A));
    check("reset_ready", 64'(bus_a.cmd_ready), 64'd1);
    check("reset_len",   64'(len_a), 64'd0);
    check("reset_coll",  64'(coll_a), 64'd0);
    check("reset_ate",   64'(ate_a), 64'd0);

    send(0, 4'd5, 4'd0, 1'b1, BORDER_A | (36'd1 << 14), 5'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    load_apple(0, 4'd6, BORDER_A | (36'd1 << 14) | (36'd1 << 15), "apple_shown");
    send(0, 4'd6, 4'd5, 1'b0, BORDER_A | (36'd1 << 14) | (36'd1 << 15), 5'd2, 1'b1, 1'b0, 1'b0, 4'd0);
    send(0, 4'd7, 4'd5, 1'b0, BORDER_A | (36'd1 << 15) | (36'd1 << 16), 5'd2, 1'b0, 1'b0, 1'b0, 4'd0);
    send(0, 4'd6, 4'd7, 1'b0, BORDER_A | (36'd1 << 15) | (36'd1 << 16), 5'd2, 1'b0, 1'b1, 1'b0, 4'd0);

    // Dead: commands and apple loads must not disturb anything.
    @(posedge clock); #1;
    drive_cmd(0, 1'b1, 4'd3, 4'd6, 1'b1);
    drive_apple(0, 1'b1, 4'd3);
    repeat (4) @(posedge clock);
    #1;
    drive_cmd(0, 1'b0, 4'd0, 4'd0, 1'b0);
    drive_apple(0, 1'b0, 4'd0);
    @(negedge clock);
    check("dead_leds",  64'(leds_a), 64'(BORDER_A | (36'd1 << 15) | (36'd1 << 16)));
    check("dead_len",   64'(len_a), 64'd2);
    check("dead_ready", 64'(bus_a.cmd_ready), 64'd0);
    check("dead_coll",  64'(coll_a), 64'd1);

    do_restart();
    check("restart_leds",  64'(leds_a), 64'(BORDER_A));
    check("restart_coll",  64'(coll_a), 64'd0);
    check("restart_len",   64'(len_a), 64'd0);
    check("restart_ready", 64'(bus_a.cmd_ready), 64'd1);

    send(0, 4'd3, 4'd0, 1'b1, BORDER_A | (36'd1 << 10), 5'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    send(0, 4'd3, 4'd3, 1'b0, BORDER_A | (36'd1 << 10), 5'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    load_apple(0, 4'd0, BORDER_A | (36'd1 << 10) | (36'd1 << 7), "apple_cell0");
    send(0, 4'd0, 4'd3, 1'b0, BORDER_A | (36'd1 << 7) | (36'd1 << 10) | (36'd1 << 20),
         5'd2, 1'b1, 1'b0, 1'b1, 4'd9);

    // Fill the whole field, then bite into it.
    do_restart();
    ef = BORDER_A;
    for (int i = 0; i < 16; i++) begin
      ef[map_a(i)] = 1'b1;
      send(0, 4'(i), 4'd0, 1'b1, ef, 5'(i + 1), 1'b0, 1'b0, 1'b0, 4'd0);
    end
    send(0, 4'd0, 4'd5, 1'b1, 36'hFFFFFFFFF, 5'd16, 1'b0, 1'b1, 1'b0, 4'd0);

    // 5x3 field.
    do_restart();
    bb = border_b();
    check("b_reset_leds", 64'(leds_b), 64'(bb));
    send(1, 4'd14, 4'd0, 1'b1, bb | (36'd1 << 26), 5'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    load_apple(1, 4'd15, bb | (36'd1 << 26), "b_apple_oob_ignored");
    send(1, 4'd15, 4'd0, 1'b0, bb | (36'd1 << 26), 5'd1, 1'b0, 1'b1, 1'b0, 4'd0);
    check("b_dead_ready", 64'(bus_b.cmd_ready), 64'd0);

    repeat (3) @(negedge clock);
    check("q_a_drained", 64'(q_a.size()), 64'd0);
    check("q_b_drained", 64'(q_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
